// File: rtl/ff_pkg.sv
// -----------------------------------------------------------------------------
// ff_pkg
// Shared definitions for the Forward-Forward datapath blocks.
//   - Q16.16 constants (Q_ONE, Q_MAX) and the fractional bit count
//   - q_square(): Q16.16 square, full 64-bit product shifted back to Q16.16,
//     returned at the 48-bit width the accumulators use
//   - goodness_state_t: controller states of goodness_calc
// -----------------------------------------------------------------------------
package ff_pkg;

    localparam int FRAC_BITS = 16;
    localparam int Q_WIDTH   = 32;
    localparam int SQ_WIDTH  = 48;

    localparam logic [Q_WIDTH-1:0] Q_ONE = 32'h0001_0000;
    localparam logic [Q_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } goodness_state_t;

    // The square of any 32-bit signed value is non-negative and at most 2^62,
    // so after the shift it always fits in 47 bits; the top bits are zero.
    function automatic logic [SQ_WIDTH-1:0] q_square(input logic signed [Q_WIDTH-1:0] a);
        logic signed [2*Q_WIDTH-1:0] prod;
        prod = a * a;
        prod = prod >>> FRAC_BITS;
        return prod[SQ_WIDTH-1:0];
    endfunction

endpackage : ff_pkg

// File: rtl/sq_acc_unit.sv
// -----------------------------------------------------------------------------
// sq_acc_unit
// Square register stage followed by a saturating unsigned accumulator.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      zero the accumulator on the next edge (takes priority)
//   in_valid   in_data carries an activation this cycle
//   in_data    Q16.16 signed activation
//   sq_valid   the square register holds a value to be accumulated
//   acc        current accumulator value
//   acc_next   value the accumulator takes on the next edge; lets the
//              controller capture the final sum without an extra cycle
// -----------------------------------------------------------------------------
module sq_acc_unit
    import ff_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  sq_valid,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic [ACC_WIDTH-1:0]  acc_next
);

    logic                 sq_valid_q, sq_valid_d;
    logic [ACC_WIDTH-1:0] sq_q, sq_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH:0]   sum_w;

    always_comb begin
        sq_valid_d = in_valid;
        sq_d       = sq_q;
        if (in_valid) begin
            sq_d = ACC_WIDTH'(q_square(Q_WIDTH'(in_data)));
        end
    end

    // The extra carry bit detects wrap; once the accumulator reaches
    // all-ones it can never grow, so saturation is sticky for the pass.
    always_comb begin
        sum_w = {1'b0, acc_q} + {1'b0, sq_q};
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (sq_valid_q) begin
            acc_d = sum_w[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_valid_q <= 1'b0;
            sq_q       <= '0;
            acc_q      <= '0;
        end else begin
            sq_valid_q <= sq_valid_d;
            sq_q       <= sq_d;
            acc_q      <= acc_d;
        end
    end

    assign sq_valid = sq_valid_q;
    assign acc      = acc_q;
    assign acc_next = acc_d;

endmodule : sq_acc_unit

// File: rtl/goodness_calc.sv
// -----------------------------------------------------------------------------
// goodness_calc
// Forward-Forward goodness G = sum(y_i^2) over one layer's activations, Q16.16.
// Streams activations from the activation buffer, one per cycle, and presents
// a saturated Q16.16 result with a one-cycle done pulse.
//
// Optional build macro: GOODNESS_MEAN_EN
//   defined   -> result is the sum shifted right by $clog2(NUM_NEURONS)
//                (mean over NUM_NEURONS); NUM_NEURONS must be a power of two
//   undefined -> result is the raw sum
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a pass (only honoured in IDLE)
//   active_neurons  activations to sum, latched at start, clamped to NUM_NEURONS
//   busy            high from the cycle after start acceptance through done
//   done            one-cycle pulse; goodness_out/overflow valid from this cycle
//   goodness_out    Q16.16 goodness, held until the next done
//   overflow        result saturated to Q_MAX, held with goodness_out
//   act_addr        activation buffer read address (registered)
//   act_en          activation buffer read enable (registered)
//   act_rdata       activation data, valid one cycle after act_en
//
// Handshake: start is a level sampled in IDLE only; a start seen in any other
// state (including the done cycle) is dropped, never queued.
//
// Timing for start accepted in cycle T with n activations:
//   act_en/act_addr=k at T+1+k, data at T+2+k, square at T+3+k,
//   done at T+n+3 (n=0: done at T+1).
// -----------------------------------------------------------------------------
module goodness_calc
    import ff_pkg::*;
#(
    parameter int NUM_NEURONS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int ACC_WIDTH   = 48
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(NUM_NEURONS):0]     active_neurons,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_WIDTH-1:0]            goodness_out,
    output logic                             overflow,
    output logic [$clog2(NUM_NEURONS)-1:0]   act_addr,
    output logic                             act_en,
    input  logic [DATA_WIDTH-1:0]            act_rdata
);

    localparam int AW = $clog2(NUM_NEURONS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] N_MAX = CW'(NUM_NEURONS);

`ifdef GOODNESS_MEAN_EN
    generate
        if ((1 << AW) != NUM_NEURONS) begin : g_pow2_check
            $error("goodness_calc: GOODNESS_MEAN_EN requires NUM_NEURONS to be a power of two");
        end
    endgenerate
`endif

    goodness_state_t       state_q, state_d;
    logic [CW-1:0]         n_q, n_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  act_en_q, act_en_d;
    logic                  rd_valid_q;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] goodness_q, goodness_d;
    logic                  overflow_q, overflow_d;

    logic                  acc_clear;
    logic [CW-1:0]         n_eff;
    logic                  sq_valid;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [ACC_WIDTH-1:0]  final_val;

    sq_acc_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sq_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .in_valid (rd_valid_q),
        .in_data  (act_rdata),
        .sq_valid (sq_valid),
        .acc      (acc),
        .acc_next (acc_next)
    );

    assign n_eff = (active_neurons > N_MAX) ? N_MAX : active_neurons;

    // The final sum is taken from acc_next so that the last square, which is
    // added on the DRAIN->DONE edge, is included without an extra cycle.
`ifdef GOODNESS_MEAN_EN
    assign final_val = acc_next >> AW;
`else
    assign final_val = acc_next;
`endif

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        addr_d     = addr_q;
        act_en_d   = 1'b0;
        acc_clear  = 1'b0;
        done_d     = 1'b0;
        goodness_d = goodness_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d       = n_eff;
                    acc_clear = 1'b1;
                    if (n_eff == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = ISSUE;
                        act_en_d = 1'b1;
                        addr_d   = '0;
                    end
                end
            end
            ISSUE: begin
                // addr_q is the address being read this cycle.
                if ({1'b0, addr_q} == n_q - 1'b1) begin
                    state_d = DRAIN;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    act_en_d = 1'b1;
                end
            end
            DRAIN: begin
                // No read data arriving means only the square register can
                // still hold a value, and it is folded in on this edge.
                if (!rd_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE && state_q != DONE) begin
            done_d = 1'b1;
            if (|final_val[ACC_WIDTH-1:DATA_WIDTH-1]) begin
                goodness_d = Q_MAX;
                overflow_d = 1'b1;
            end else begin
                goodness_d = final_val[DATA_WIDTH-1:0];
                overflow_d = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            addr_q     <= '0;
            act_en_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            goodness_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            act_en_q   <= act_en_d;
            rd_valid_q <= act_en_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
            goodness_q <= goodness_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign goodness_out = goodness_q;
    assign overflow     = overflow_q;
    assign act_addr     = addr_q;
    assign act_en       = act_en_q;

endmodule : goodness_calc
